// File: rtl/bitfield_extract_arbiter.sv
// Two-requester bit-field extractor: round-robin grant, one shared extract stage,
// and a tagged valid/ready response channel. Only one operation is in flight at a time.
module bitfield_extract_arbiter #(
  parameter int DATA_W  = 64,
  parameter int FIELD_W = 16,
  parameter int LSB_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_word,
  input  logic [LSB_W-1:0]   req0_lsb,
  input  logic [4:0]         req0_len,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_word,
  input  logic [LSB_W-1:0]   req1_lsb,
  input  logic [4:0]         req1_len,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [FIELD_W-1:0] rsp_data,
  output logic               rsp_err
);

  localparam int SUM_W = LSB_W + 2;
  localparam logic [4:0]       FIELD_LEN = 5'(FIELD_W);
  localparam logic [SUM_W-1:0] DATA_LIM  = SUM_W'(DATA_W);
  localparam logic [FIELD_W:0] MASK_ONE  = (FIELD_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXTRACT = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               rr_ptr_r;
  logic [DATA_W-1:0]  word_r;
  logic [LSB_W-1:0]   lsb_r;
  logic [4:0]         len_r;
  logic               id_r;

  logic               grant_valid_s;
  logic               grant_id_s;
  logic [4:0]         eff_len_s;
  logic [DATA_W-1:0]  shifted_s;
  logic [FIELD_W:0]   mask_s;
  logic [FIELD_W-1:0] field_s;
  logic [SUM_W-1:0]   bound_s;
  logic               err_s;

  // Round-robin grant; readies are only offered in IDLE and never while reset is held.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      if (rr_ptr_r ? req1_valid : req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = rr_ptr_r;
      end else if (rr_ptr_r ? req0_valid : req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~rr_ptr_r;
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
    end
    req0_ready = grant_valid_s & ~grant_id_s;
    req1_ready = grant_valid_s &  grant_id_s;
  end

  // Next-state logic for the IDLE -> EXTRACT -> RESPOND sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = grant_valid_s ? EXTRACT : IDLE;
      EXTRACT: state_s = RESPOND;
      RESPOND: state_s = (rsp_valid && rsp_ready) ? IDLE : RESPOND;
      default: state_s = IDLE;
    endcase
  end

  // Extraction datapath on the latched operands; the bound sum is wide enough never to wrap.
  always_comb begin
    if ((len_r == 5'd0) || (len_r > FIELD_LEN)) begin
      eff_len_s = FIELD_LEN;
    end else begin
      eff_len_s = len_r;
    end
    shifted_s = word_r >> lsb_r;
    mask_s    = (MASK_ONE << eff_len_s) - MASK_ONE;
    field_s   = shifted_s[FIELD_W-1:0] & mask_s[FIELD_W-1:0];
    bound_s   = SUM_W'(lsb_r) + SUM_W'(eff_len_s);
    err_s     = (bound_s > DATA_LIM);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture: inputs are only looked at in the handshake cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r <= '0;
      lsb_r  <= '0;
      len_r  <= 5'd0;
      id_r   <= 1'b0;
    end else if (grant_valid_s) begin
      word_r <= grant_id_s ? req1_word : req0_word;
      lsb_r  <= grant_id_s ? req1_lsb  : req0_lsb;
      len_r  <= grant_id_s ? req1_len  : req0_len;
      id_r   <= grant_id_s;
    end
  end

  // Response registers and round-robin pointer; data/err hold their last value in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rr_ptr_r  <= 1'b0;
    end else begin
      case (state_r)
        EXTRACT: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
          rsp_data  <= field_s;
          rsp_err   <= err_s;
        end
        RESPOND: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_r  <= ~rsp_id;
          end
        end
        default: begin
          rsp_valid <= rsp_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitfield_extract_arbiter.sv
// Self-checking bench for bitfield_extract_arbiter: directed test-plan cases plus
// randomized operations checked against an arithmetic reference model.
module tb_bitfield_extract_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_word, req1_word;
  logic [5:0]  req0_lsb, req1_lsb;
  logic [4:0]  req0_len, req1_len;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;

  int   checks = 0;
  int   failures = 0;
  logic exp_rr;

  logic [1:0]  op_rdy;
  logic        op_id, op_err, op_timeout;
  logic [15:0] op_data;
  int          op_lat;

  always #5 clk = ~clk;

  bitfield_extract_arbiter #(.DATA_W(64), .FIELD_W(16), .LSB_W(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_word(req0_word),
    .req0_lsb(req0_lsb), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_word(req1_word),
    .req1_lsb(req1_lsb), .req1_len(req1_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  function automatic void ref_extract(input logic [63:0] w, input int lsb, input int len,
                                      output logic [15:0] d, output logic e);
    int eff;
    logic [63:0] sh;
    eff = (len == 0 || len > 16) ? 16 : len;
    sh  = w >> lsb;
    d   = 16'(sh & ((64'd1 << eff) - 64'd1));
    e   = (lsb + eff) > 64;
  endfunction

  // Drives one operation, releases/scrambles operands after the handshake, then completes it.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [63:0] w0, input logic [5:0] l0, input logic [4:0] n0,
                        input logic [63:0] w1, input logic [5:0] l1, input logic [4:0] n1,
                        input int stall);
    bit got;
    op_timeout = 1'b0; op_rdy = 2'b00; op_lat = 0;
    @(posedge clk); #1;
    req0_valid = v0; req0_word = w0; req0_lsb = l0; req0_len = n0;
    req1_valid = v1; req1_word = w1; req1_lsb = l1; req1_len = n1;
    rsp_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    if (!got) begin
      op_timeout = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
    end else begin
      op_rdy = {req1_ready, req0_ready};
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_word = {$urandom, $urandom}; req0_lsb = 6'($urandom); req0_len = 5'($urandom);
      req1_word = {$urandom, $urandom}; req1_lsb = 6'($urandom); req1_len = 5'($urandom);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        op_lat++;
        if (rsp_valid) got = 1'b1;
      end
      if (!got) begin
        op_timeout = 1'b1;
      end else begin
        op_id = rsp_id; op_data = rsp_data; op_err = rsp_err;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_word = 64'h0; req0_lsb = 6'd0; req0_len = 5'd0;
    req1_word = 64'h0; req1_lsb = 6'd0; req1_len = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 000", {rsp_valid, rsp_id, rsp_err});
    end
    checks++;
    if (rsp_data !== 16'h0000) begin
      failures++; $display("FAIL reset_data: got %h expected 0000", rsp_data);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
    end
    exp_rr = 1'b0;
  endtask

  // Both valids held from reset release with rsp_ready=1: expect 0,1,0,1 every 3 cycles.
  task automatic test_round_robin;
    int acc_cyc[$];
    logic acc_id[$];
    logic rsp_ids[$];
    rsp_ready = 1'b1;
    req0_word = 64'h1; req1_word = 64'h2;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(c);
        acc_id.push_back(req1_ready);
      end
      if (rsp_valid) rsp_ids.push_back(rsp_id);
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || rsp_ids.size() != 4) begin
      failures++;
      $display("FAIL rr_count: accepts=%0d responses=%0d expected 4 and 4", acc_cyc.size(), rsp_ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_id[i] !== 1'(i % 2) || rsp_ids[i] !== 1'(i % 2)) begin
          failures++;
          $display("FAIL rr_order[%0d]: grant=%b rsp_id=%b expected %0d", i, acc_id[i], rsp_ids[i], i % 2);
        end
        checks++;
        if (acc_cyc[i] != 3 * i) begin
          failures++; $display("FAIL rr_interval[%0d]: cycle %0d expected %0d", i, acc_cyc[i], 3 * i);
        end
      end
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_directed;
    run_op(1'b1, 1'b0, 64'h123, 6'd4, 5'd0, 64'h0, 6'd0, 5'd0, 0);
    checks++;
    if (op_timeout || op_rdy !== 2'b01 || op_id !== 1'b0 || op_data !== 16'h0012 || op_err !== 1'b0 || op_lat != 2) begin
      failures++;
      $display("FAIL slice0: to=%b rdy=%b id=%b data=%h err=%b lat=%0d expected 0 01 0 0012 0 2",
               op_timeout, op_rdy, op_id, op_data, op_err, op_lat);
    end
    run_op(1'b0, 1'b1, 64'h0, 6'd0, 5'd0, 64'h00000456_00000000, 6'd36, 5'd16, 1);
    checks++;
    if (op_timeout || op_rdy !== 2'b10 || op_id !== 1'b1 || op_data !== 16'h0045 || op_err !== 1'b0 || op_lat != 2) begin
      failures++;
      $display("FAIL upper_slice: to=%b rdy=%b id=%b data=%h err=%b lat=%0d expected 0 10 1 0045 0 2",
               op_timeout, op_rdy, op_id, op_data, op_err, op_lat);
    end
    run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd56, 5'd16, 64'h0, 6'd0, 5'd0, 2);
    checks++;
    if (op_timeout || op_id !== 1'b0 || op_data !== 16'h00FF || op_err !== 1'b1) begin
      failures++;
      $display("FAIL bounds_err: to=%b id=%b data=%h err=%b expected 0 0 00ff 1",
               op_timeout, op_id, op_data, op_err);
    end
    exp_rr = 1'b1;
  endtask

  task automatic test_backpressure;
    logic [15:0] d0, exp_d;
    logic        e0, exp_e;
    logic        id0;
    bit          got;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_word = 64'hDEAD_BEEF_CAFE_F00D; req0_lsb = 6'd8; req0_len = 5'd12;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_word = 64'h0000_0000_0000_ABCD; req1_lsb = 6'd0; req1_len = 5'd8;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL bp_rsp_timeout: rsp_valid never rose");
    end
    id0 = rsp_id; d0 = rsp_data; e0 = rsp_err;
    ref_extract(64'hDEAD_BEEF_CAFE_F00D, 8, 12, exp_d, exp_e);
    checks++;
    if (id0 !== 1'b0 || d0 !== exp_d || e0 !== exp_e) begin
      failures++; $display("FAIL bp_data: id=%b data=%h err=%b expected 0 %h %b", id0, d0, e0, exp_d, exp_e);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== d0 || rsp_err !== e0 || {req1_ready, req0_ready} !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold[%0d]: v=%b id=%b data=%h err=%b rdy=%b expected 1 %b %h %b 00",
                 k, rsp_valid, rsp_id, rsp_data, rsp_err, {req1_ready, req0_ready}, id0, d0, e0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++; $display("FAIL bp_next_accept: rsp_valid=%b req1_ready=%b expected 0 1", rsp_valid, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    checks++;
    if (!got || rsp_id !== 1'b1 || rsp_data !== 16'h00CD || rsp_err !== 1'b0) begin
      failures++; $display("FAIL bp_second: got=%b id=%b data=%h err=%b expected 1 1 00cd 0", got, rsp_id, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_rr = 1'b0;
  endtask

  task automatic test_reset_midop;
    int stale;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_word = 64'h0000_0000_0000_7777; req0_lsb = 6'd0; req0_len = 5'd0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL midop_accept: req0_ready=%b expected 1", req0_ready);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
      failures++; $display("FAIL midop_reset_now: rsp_valid=%b rdy=%b expected 0 00", rsp_valid, {req1_ready, req0_ready});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midop_reset_hold: rsp_valid=%b expected 0", rsp_valid);
    end
    req1_valid = 1'b0;
    reset = 1'b0;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL midop_stale: rsp_valid seen %0d cycles expected 0", stale);
    end
    exp_rr = 1'b0;
    run_op(1'b0, 1'b1, 64'h0, 6'd0, 5'd0, 64'h0000_0000_0012_3400, 6'd8, 5'd8, 0);
    checks++;
    if (op_timeout || op_id !== 1'b1 || op_data !== 16'h0034 || op_err !== 1'b0) begin
      failures++; $display("FAIL midop_after: to=%b id=%b data=%h err=%b expected 0 1 0034 0",
                           op_timeout, op_id, op_data, op_err);
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_random;
    logic        v0, v1, eid;
    logic [63:0] w0, w1;
    logic [5:0]  l0, l1;
    logic [4:0]  n0, n1;
    logic [15:0] ed;
    logic        ee;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      v0 = sel[0]; v1 = sel[1];
      w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
      l0 = 6'($urandom_range(0, 63)); l1 = 6'($urandom_range(0, 63));
      n0 = 5'($urandom_range(0, 31)); n1 = 5'($urandom_range(0, 31));
      eid = (v0 && v1) ? exp_rr : v1;
      if (eid) ref_extract(w1, int'(l1), int'(n1), ed, ee);
      else     ref_extract(w0, int'(l0), int'(n0), ed, ee);
      run_op(v0, v1, w0, l0, n0, w1, l1, n1, $urandom_range(0, 3));
      checks++;
      if (op_timeout || op_rdy !== (eid ? 2'b10 : 2'b01) || op_id !== eid || op_data !== ed || op_err !== ee || op_lat != 2) begin
        failures++;
        $display("FAIL rand[%0d]: to=%b rdy=%b id=%b data=%h err=%b lat=%0d expected id=%b data=%h err=%b lat=2",
                 i, op_timeout, op_rdy, op_id, op_data, op_err, op_lat, eid, ed, ee);
      end
      exp_rr = ~eid;
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_directed;
    test_backpressure;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
